bram_group_read_port: RTL and testbench

- Read-side front end placed directly upstream of the bram group.
- Accepts read requests from a client (conv, datasaver or misc) with a valid/ready handshake and drives the bram group's per-bank read enables and addresses.
- Tracks the fixed BRAM read latency and captures the returned data into a small response FIFO.
- Presents responses to the client in order with a valid/ready handshake. Credit-based admission means no read data is ever dropped under back-pressure.

---
 rtl/bram_group_read_port.sv | 108 ++++++++++
 tb/tb_bram_group_read_port.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bram_group_read_port.sv
// Read front end for the bram group: credit-gated request issue, fixed-latency
// tracking pipe and an in-order response FIFO that cannot overflow.
module bram_group_read_port #(
  parameter int BANK_NUM        = 4,
  parameter int BANK_ADDR_WIDTH = 12,
  parameter int BANK_DATA_WIDTH = 64,
  parameter int READ_LATENCY    = 2,
  parameter int FIFO_DEPTH      = 4,
  parameter int TAG_WIDTH       = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_p,
  input  logic                                 req_valid_i,
  output logic                                 req_ready_o,
  input  logic [BANK_NUM-1:0]                  req_bank_en_i,
  input  logic [BANK_NUM*BANK_ADDR_WIDTH-1:0]  req_addr_i,
  input  logic [TAG_WIDTH-1:0]                 req_tag_i,
  output logic [BANK_NUM-1:0]                  read_bank_en_o,
  output logic [BANK_NUM*BANK_ADDR_WIDTH-1:0]  read_addr_o,
  input  logic [BANK_NUM*BANK_DATA_WIDTH-1:0]  read_data_i,
  output logic                                 resp_valid_o,
  input  logic                                 resp_ready_i,
  output logic [BANK_NUM*BANK_DATA_WIDTH-1:0]  resp_data_o,
  output logic [BANK_NUM-1:0]                  resp_bank_en_o,
  output logic [TAG_WIDTH-1:0]                 resp_tag_o,
  output logic [$clog2(FIFO_DEPTH):0]          occupancy_o
);
  localparam int DW = BANK_NUM * BANK_DATA_WIDTH;
  localparam int OW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [OW-1:0] DEPTH_C = OW'(FIFO_DEPTH);

  // Handshake rule for both ports: a transfer happens on a cycle where valid
  // and ready are both high; ready never depends on the same port's valid.
  logic           accept, push, pop;
  logic [OW-1:0]  occ_q, occ_d;
  logic [OW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;

  logic [READ_LATENCY-1:0] pipe_vld_q;
  logic [BANK_NUM-1:0]     pipe_en_q  [READ_LATENCY];
  logic [TAG_WIDTH-1:0]    pipe_tag_q [READ_LATENCY];

  logic [DW-1:0]           fifo_data_q [FIFO_DEPTH];
  logic [BANK_NUM-1:0]     fifo_en_q   [FIFO_DEPTH];
  logic [TAG_WIDTH-1:0]    fifo_tag_q  [FIFO_DEPTH];
  logic [DW-1:0]           cap_data;

  // Occupancy counts a request from acceptance until its response pops, so
  // admission alone guarantees a free FIFO slot when the data arrives.
  assign req_ready_o    = (occ_q < DEPTH_C) && !rst_p;
  assign accept         = req_valid_i && req_ready_o;
  assign read_bank_en_o = accept ? req_bank_en_i : '0;
  assign read_addr_o    = req_addr_i;

  assign push         = pipe_vld_q[READ_LATENCY-1];
  assign resp_valid_o = (cnt_q != '0);
  assign pop          = resp_valid_o && resp_ready_i;
  assign occ_d        = occ_q + OW'(accept) - OW'(pop);
  assign cnt_d        = cnt_q + OW'(push) - OW'(pop);
  assign occupancy_o  = occ_q;

  always_comb begin
    cap_data = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      if (pipe_en_q[READ_LATENCY-1][b])
        cap_data[b*BANK_DATA_WIDTH +: BANK_DATA_WIDTH] = read_data_i[b*BANK_DATA_WIDTH +: BANK_DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_p) begin
      pipe_vld_q <= '0;
      occ_q      <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      pipe_vld_q[0] <= accept;
      for (int i = 1; i < READ_LATENCY; i++) pipe_vld_q[i] <= pipe_vld_q[i-1];
      occ_q <= occ_d;
      cnt_q <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Payload side carries no reset; only the valid bits above qualify it.
  always_ff @(posedge clk) begin
    pipe_en_q[0]  <= req_bank_en_i;
    pipe_tag_q[0] <= req_tag_i;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_en_q[i]  <= pipe_en_q[i-1];
      pipe_tag_q[i] <= pipe_tag_q[i-1];
    end
    if (push && !rst_p) begin
      fifo_data_q[wr_ptr_q] <= cap_data;
      fifo_en_q[wr_ptr_q]   <= pipe_en_q[READ_LATENCY-1];
      fifo_tag_q[wr_ptr_q]  <= pipe_tag_q[READ_LATENCY-1];
    end
  end

  // Head is gated so the response bus reads as zero whenever nothing is queued.
  assign resp_data_o    = resp_valid_o ? fifo_data_q[rd_ptr_q] : '0;
  assign resp_bank_en_o = resp_valid_o ? fifo_en_q[rd_ptr_q]   : '0;
  assign resp_tag_o     = resp_valid_o ? fifo_tag_q[rd_ptr_q]  : '0;

endmodule

// File: tb/tb_bram_group_read_port.sv
// Bench for bram_group_read_port: BRAM group model, request driver, and a
// scoreboard monitor comparing responses, occupancy and latency.
module tb_bram_group_read_port;
  localparam int NB = 4, AW = 12, DWB = 64, TW = 4, DEPTH = 4, RL = 2;
  localparam int DW = NB * DWB;
  localparam int OW = $clog2(DEPTH) + 1;
  localparam int EN_LO = 32 + TW;
  localparam int D_LO  = 32 + TW + NB;
  localparam int EXP_W = DW + NB + TW + 32;

  logic              clk, rst_p;
  logic              req_valid_i, req_ready_o, resp_valid_o, resp_ready_i;
  logic [NB-1:0]     req_bank_en_i, read_bank_en_o, resp_bank_en_o;
  logic [NB*AW-1:0]  req_addr_i, read_addr_o;
  logic [TW-1:0]     req_tag_i, resp_tag_o;
  logic [DW-1:0]     read_data_i, resp_data_o, bram_s1;
  logic [OW-1:0]     occupancy_o;

  int checks = 0, failures = 0, cyc = 0;
  bit strict_lat = 0, mon_en = 0, rand_done = 0;
  logic [EXP_W-1:0] exp_q[$];

  bram_group_read_port #(
    .BANK_NUM(NB), .BANK_ADDR_WIDTH(AW), .BANK_DATA_WIDTH(DWB),
    .READ_LATENCY(RL), .FIFO_DEPTH(DEPTH), .TAG_WIDTH(TW)
  ) dut (
    .clk(clk), .rst_p(rst_p),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_bank_en_i(req_bank_en_i), .req_addr_i(req_addr_i), .req_tag_i(req_tag_i),
    .read_bank_en_o(read_bank_en_o), .read_addr_o(read_addr_o), .read_data_i(read_data_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_data_o(resp_data_o), .resp_bank_en_o(resp_bank_en_o), .resp_tag_o(resp_tag_o),
    .occupancy_o(occupancy_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- BRAM group model ----------------
  function automatic logic [DWB-1:0] mem_word(input int b, input logic [AW-1:0] a);
    return {8'(b) ^ 8'hA5, a, ~a, (32'(a) * 32'h01000193) + 32'(b * 7)};
  endfunction

  // Disabled lanes return noise so any missing lane masking shows up.
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++)
      bram_s1[b*DWB +: DWB] <= read_bank_en_o[b] ? mem_word(b, read_addr_o[b*AW +: AW])
                                                 : {$urandom, $urandom};
    read_data_i <= bram_s1;
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [NB-1:0] en, input logic [NB*AW-1:0] addr,
                          input logic [TW-1:0] tag);
    logic [DW-1:0] d;
    d = '0;
    for (int b = 0; b < NB; b++)
      if (en[b]) d[b*DWB +: DWB] = mem_word(b, addr[b*AW +: AW]);
    exp_q.push_back({d, en, tag, 32'(cyc)});
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [NB-1:0] en, input logic [NB*AW-1:0] addr,
                       input logic [TW-1:0] tag, input int max_wait);
    bit ok;
    ok = 0;
    for (int w = 0; w < max_wait && !ok; w++) begin
      @(negedge clk);
      req_valid_i = 1'b1; req_bank_en_i = en; req_addr_i = addr; req_tag_i = tag;
      #1;
      if (req_ready_o) begin
        ok = 1;
        push_exp(en, addr, tag);
        chk("issue_bank_en", DW'(read_bank_en_o), DW'(en));
        chk("issue_addr", DW'(read_addr_o), DW'(addr));
      end
    end
    if (!ok) chk("issue_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk); @(negedge clk);
    chk("drain_empty", DW'(exp_q.size()), 0);
  endtask

  function automatic logic [NB*AW-1:0] rand_addr();
    logic [NB*AW-1:0] a;
    for (int b = 0; b < NB; b++) a[b*AW +: AW] = AW'($urandom);
    return a;
  endfunction

  // ---------------- scoreboard monitor ----------------
  int exp_occ;
  logic [EXP_W-1:0] e;
  initial forever begin
    @(negedge clk); #2;
    if (mon_en && !rst_p) begin
      exp_occ = 0;
      foreach (exp_q[i]) if (int'(exp_q[i][31:0]) < cyc) exp_occ++;
      chk("occupancy", DW'(occupancy_o), DW'(exp_occ));
      chk("occupancy_bound", DW'(occupancy_o <= OW'(DEPTH)), 1);
      chk("req_ready", DW'(req_ready_o), DW'(exp_occ < DEPTH));
      if (resp_valid_o && resp_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", DW'(resp_tag_o), 'x);
        end else begin
          e = exp_q.pop_front();
          chk("resp_data", resp_data_o, e[D_LO +: DW]);
          chk("resp_bank_en", DW'(resp_bank_en_o), DW'(e[EN_LO +: NB]));
          chk("resp_tag", DW'(resp_tag_o), DW'(e[32 +: TW]));
          chk("min_latency", DW'(cyc - int'(e[31:0]) >= RL + 1), 1);
          if (strict_lat) chk("exact_latency", DW'(cyc - int'(e[31:0])), DW'(RL + 1));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int acc;
  logic [NB*AW-1:0] a1;
  initial begin
    rst_p = 1'b1; req_valid_i = 1'b1; req_bank_en_i = '1; req_addr_i = '0; req_tag_i = '0;
    resp_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", DW'(req_ready_o), 0);
    chk("rst_read_en", DW'(read_bank_en_o), 0);
    @(negedge clk); rst_p = 1'b0; req_valid_i = 1'b0; #1;
    chk("post_rst_resp_valid", DW'(resp_valid_o), 0);
    chk("post_rst_occupancy", DW'(occupancy_o), 0);
    chk("post_rst_req_ready", DW'(req_ready_o), 1);
    chk("post_rst_resp_data", resp_data_o, 0);
    mon_en = 1;

    // Single read, banks 0 and 2 enabled, exact 3-cycle latency.
    resp_ready_i = 1'b1; strict_lat = 1;
    a1 = '0; a1[0*AW +: AW] = 12'h008; a1[2*AW +: AW] = 12'h010;
    a1[1*AW +: AW] = 12'h3AB; a1[3*AW +: AW] = 12'h7CD;
    issue(4'b0101, a1, 4'd5, 1);
    drain(20);

    // Eight back-to-back requests, ready must never drop.
    for (int t = 0; t < 8; t++) issue(4'(t + 1), rand_addr(), 4'(t), 1);
    drain(30);

    // Zero-mask request still produces one all-zero response.
    issue(4'b0000, rand_addr(), 4'd9, 1);
    drain(20);
    strict_lat = 0;

    // Back-pressure: six attempts with consumer stalled, exactly four admitted.
    @(negedge clk); resp_ready_i = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req_valid_i = 1'b1; req_bank_en_i = 4'b1111; req_addr_i = {4{12'(12'h100 + acc)}};
      req_tag_i = 4'(acc);
      #1;
      if (req_ready_o) begin
        push_exp(req_bank_en_i, req_addr_i, req_tag_i);
        acc++;
      end
    end
    @(posedge clk); #1; req_valid_i = 1'b0;
    chk("bp_accepted", DW'(acc), 4);
    @(negedge clk); #1;
    chk("bp_occupancy_full", DW'(occupancy_o), 4);
    chk("bp_req_ready_low", DW'(req_ready_o), 0);
    @(negedge clk); resp_ready_i = 1'b1;
    issue(4'b1111, {4{12'h104}}, 4'd4, 10);
    issue(4'b1111, {4{12'h105}}, 4'd5, 10);
    drain(30);

    // Reset with two reads in the pipe and two in the FIFO.
    @(negedge clk); resp_ready_i = 1'b0;
    for (int t = 0; t < 4; t++) issue(4'b1011, rand_addr(), 4'(t + 10), 1);
    @(negedge clk);
    rst_p = 1'b1; exp_q.delete();
    req_valid_i = 1'b1; req_bank_en_i = 4'b1111;
    #1;
    chk("midrst_req_ready", DW'(req_ready_o), 0);
    chk("midrst_read_en", DW'(read_bank_en_o), 0);
    @(negedge clk); rst_p = 1'b0; req_valid_i = 1'b0; #1;
    chk("midrst_resp_valid", DW'(resp_valid_o), 0);
    chk("midrst_occupancy", DW'(occupancy_o), 0);
    chk("midrst_req_ready_up", DW'(req_ready_o), 1);
    chk("midrst_resp_data", resp_data_o, 0);
    chk("midrst_resp_tag", DW'(resp_tag_o), 0);
    chk("midrst_resp_en", DW'(resp_bank_en_o), 0);
    resp_ready_i = 1'b1;
    repeat (10) @(negedge clk);
    issue(4'b0110, rand_addr(), 4'd3, 1);
    drain(20);

    // Random traffic with random consumer stalls.
    rand_done = 0;
    fork
      begin
        for (int n = 0; n < 1000; n++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          issue(4'($urandom_range(0, 15)), rand_addr(), 4'($urandom_range(0, 15)), 200);
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(negedge clk);
          resp_ready_i = 1'($urandom_range(0, 1));
        end
      end
    join
    @(negedge clk); resp_ready_i = 1'b1;
    drain(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
